uart_rx_oversampled: RTL and testbench



---
 rtl/uart_rx_oversampled.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled
//   8N1 UART receiver (LSB first) with Oversample ticks per bit period.
//   The received byte is presented through a single-entry output register
//   with a valid/ready handshake toward the downstream skid buffer.
//
// Handshake: valid_o is raised when data_o holds an unconsumed byte and is
// held, with data_o stable, until the cycle in which ready_i is also high;
// a transfer happens exactly in a cycle where valid_o && ready_i.
//
// Ports
//   clk_i        system clock
//   rst_i        synchronous, active-high reset
//   rx_i         asynchronous serial input, idles high
//   data_o[7:0]  received byte
//   valid_o      data_o holds an unconsumed byte
//   ready_i      downstream accepts the byte
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   overrun_o    one-cycle pulse: completed byte dropped, output register full
//   dbg_state    current receiver FSM state (debug observation)
module uart_rx_oversampled #(
  parameter int ClkFreqHz  = 16_000_000,
  parameter int BaudRate   = 1_000_000,
  parameter int Oversample = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic [2:0] dbg_state
);

  localparam int Divisor = ClkFreqHz / (BaudRate * Oversample);
  localparam int TickW   = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam int SampW   = $clog2(Oversample);

  if (Divisor < 1) begin : g_bad_divisor
    $error("uart_rx_oversampled: Divisor must be >= 1");
  end
  if ((Oversample < 4) || (Oversample % 2 != 0)) begin : g_bad_oversample
    $error("uart_rx_oversampled: Oversample must be even and >= 4");
  end

  localparam logic [TickW-1:0] TickLast = TickW'(Divisor - 1);
  localparam logic [SampW-1:0] SampMid  = SampW'(Oversample / 2 - 1);
  localparam logic [SampW-1:0] SampLast = SampW'(Oversample - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              rx_meta;
  logic              rx_s;
  logic [TickW-1:0]  tick_cnt;
  logic              tick;
  logic [SampW-1:0]  sample_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_reg;
  logic              shift_en;
  logic              deliver;
  logic              frame_err;
  logic              load_ok;

  assign dbg_state = state;
  assign tick      = (tick_cnt == TickLast);
  assign load_ok   = !valid_o || ready_i;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Held at zero in IDLE so the tick phase starts at the detected start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state == IDLE) || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Sample counter restarts on every state change; within DATA it simply
  // wraps once per bit period.
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_next != state)) begin
      sample_cnt <= '0;
    end else if (tick) begin
      sample_cnt <= (sample_cnt == SampLast) ? '0 : sample_cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    deliver    = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      START: begin
        // Mid start bit: a line back high means the edge was a glitch.
        if (tick && (sample_cnt == SampMid)) begin
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && (sample_cnt == SampLast)) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (tick && (sample_cnt == SampLast)) begin
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (state == START) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      shift_reg[bit_cnt] <= rx_s;
      bit_cnt            <= bit_cnt + 3'd1;
    end
  end

  // Output register: a delivery wins over the handshake clear, so a byte
  // arriving in the same cycle as a transfer keeps valid_o high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= frame_err;
      overrun_o   <= deliver && !load_ok;
      if (deliver && load_ok) begin
        data_o  <= shift_reg;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
module tb_uart_rx_oversampled;

  localparam int BIT = 16;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;
  int deliv_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx_oversampled dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_i       (rx),
    .data_o     (data),
    .valid_o    (valid),
    .ready_i    (ready),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: pops an expected byte on every handshake and counts
  // error pulse cycles.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid === 1'b1 && ready === 1'b1) begin
        logic [7:0] exp;
        deliv_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL deliver_unexpected: got=%h required=none", data);
        end else begin
          exp = exp_q.pop_front();
          if (data !== exp) begin
            bad++;
            $display("FAIL deliver_data: got=%h required=%h", data, exp);
          end
        end
      end
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (frame_err === 1'b1 && overrun === 1'b1) begin
        total++;
        bad++;
        $display("FAIL pulse_overlap: frame_err=1 overrun=1 required=not both");
      end
    end
  end

  // Driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives start, 8 data bits LSB first and the given stop level; the line
  // is left at the stop level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT);
    end
    rx = stop;
    wait_clks(BIT);
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b1;
    wait_clks(3);
    total++;
    if (valid !== 1'b0 || data !== 8'h00) begin
      bad++;
      $display("FAIL reset_out: valid=%b data=%h required valid=0 data=00", valid, data);
    end
    total++;
    if (frame_err !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_pulses: frame_err=%b overrun=%b required 0 0", frame_err, overrun);
    end
    total++;
    if (dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL reset_state: got=%0d required=%0d", dbg_state, S_IDLE);
    end
    rst = 1'b0;
    wait_clks(BIT);
  endtask

  task automatic test_basic;
    int lat;
    int d0;
    int f0;
    int o0;
    d0 = deliv_cnt; f0 = fe_cnt; o0 = ov_cnt;
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (valid !== 1'b1 && lat < 300) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    wait_clks(BIT);
    total++;
    if (lat < 154 || lat > 156) begin
      bad++;
      $display("FAIL basic_latency: got=%0d required=155+-1", lat);
    end
    total++;
    if (deliv_cnt - d0 != 1) begin
      bad++;
      $display("FAIL basic_count: got=%0d required=1", deliv_cnt - d0);
    end
    total++;
    if (fe_cnt != f0 || ov_cnt != o0) begin
      bad++;
      $display("FAIL basic_errors: fe=%0d ov=%0d required 0 0", fe_cnt - f0, ov_cnt - o0);
    end
  endtask

  task automatic test_glitch;
    int d0;
    int f0;
    int o0;
    d0 = deliv_cnt; f0 = fe_cnt; o0 = ov_cnt;
    rx = 1'b0;
    wait_clks(4);
    rx = 1'b1;
    total++;
    if (dbg_state !== S_START) begin
      bad++;
      $display("FAIL glitch_start: got=%0d required=%0d", dbg_state, S_START);
    end
    wait_clks(7);
    total++;
    if (dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL glitch_idle: got=%0d required=%0d", dbg_state, S_IDLE);
    end
    wait_clks(BIT * 2);
    total++;
    if (deliv_cnt != d0 || fe_cnt != f0 || ov_cnt != o0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL glitch_quiet: deliv=%0d fe=%0d ov=%0d valid=%b required 0 0 0 0",
               deliv_cnt - d0, fe_cnt - f0, ov_cnt - o0, valid);
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wait_clks(BIT);
    total++;
    if (deliv_cnt - d0 != 1) begin
      bad++;
      $display("FAIL glitch_next: got=%0d required=1", deliv_cnt - d0);
    end
  endtask

  task automatic test_frame_error;
    int d0;
    int f0;
    d0 = deliv_cnt; f0 = fe_cnt;
    send_frame(8'h5A, 1'b0);
    total++;
    if (dbg_state !== S_BREAK) begin
      bad++;
      $display("FAIL ferr_break: got=%0d required=%0d", dbg_state, S_BREAK);
    end
    wait_clks(40 - BIT);
    rx = 1'b1;
    wait_clks(BIT * 2);
    total++;
    if (fe_cnt - f0 != 1) begin
      bad++;
      $display("FAIL ferr_pulse: got=%0d required=1", fe_cnt - f0);
    end
    total++;
    if (deliv_cnt != d0 || valid !== 1'b0) begin
      bad++;
      $display("FAIL ferr_discard: deliv=%0d valid=%b required 0 0", deliv_cnt - d0, valid);
    end
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    wait_clks(BIT);
    total++;
    if (deliv_cnt - d0 != 1) begin
      bad++;
      $display("FAIL ferr_next: got=%0d required=1", deliv_cnt - d0);
    end
  endtask

  task automatic test_overrun;
    int o0;
    int d0;
    o0 = ov_cnt; d0 = deliv_cnt;
    ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    wait_clks(BIT);
    total++;
    if (valid !== 1'b1 || data !== 8'h11) begin
      bad++;
      $display("FAIL ovr_hold: valid=%b data=%h required valid=1 data=11", valid, data);
    end
    total++;
    if (ov_cnt - o0 != 1) begin
      bad++;
      $display("FAIL ovr_pulse: got=%0d required=1", ov_cnt - o0);
    end
    ready = 1'b1;
    wait_clks(2);
    total++;
    if (valid !== 1'b0 || deliv_cnt - d0 != 1) begin
      bad++;
      $display("FAIL ovr_drain: valid=%b deliv=%0d required 0 1", valid, deliv_cnt - d0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat [8];
    int d0;
    int f0;
    int o0;
    pat = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E, 8'hE7};
    d0 = deliv_cnt; f0 = fe_cnt; o0 = ov_cnt;
    for (int i = 0; i < 8; i++) exp_q.push_back(pat[i]);
    for (int i = 0; i < 8; i++) send_frame(pat[i], 1'b1);
    wait_clks(BIT);
    total++;
    if (deliv_cnt - d0 != 8) begin
      bad++;
      $display("FAIL b2b_count: got=%0d required=8", deliv_cnt - d0);
    end
    total++;
    if (fe_cnt != f0 || ov_cnt != o0) begin
      bad++;
      $display("FAIL b2b_errors: fe=%0d ov=%0d required 0 0", fe_cnt - f0, ov_cnt - o0);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    int d0;
    int f0;
    int o0;
    b = 8'hC3;
    d0 = deliv_cnt; f0 = fe_cnt; o0 = ov_cnt;
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_clks(BIT);
    end
    rx = b[4];
    wait_clks(BIT / 2);
    rst = 1'b1;
    rx  = 1'b1;
    wait_clks(4);
    total++;
    if (valid !== 1'b0 || data !== 8'h00 || dbg_state !== S_IDLE) begin
      bad++;
      $display("FAIL rst_mid_out: valid=%b data=%h state=%0d required 0 00 0",
               valid, data, dbg_state);
    end
    rst = 1'b0;
    wait_clks(BIT * 4);
    total++;
    if (deliv_cnt != d0 || fe_cnt != f0 || ov_cnt != o0) begin
      bad++;
      $display("FAIL rst_mid_quiet: deliv=%0d fe=%0d ov=%0d required 0 0 0",
               deliv_cnt - d0, fe_cnt - f0, ov_cnt - o0);
    end
    exp_q.push_back(8'h96);
    send_frame(8'h96, 1'b1);
    wait_clks(BIT);
    total++;
    if (deliv_cnt - d0 != 1) begin
      bad++;
      $display("FAIL rst_mid_next: got=%0d required=1", deliv_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
